// File: rtl/boxcar_filter_mc.sv
// Multi-channel moving-average filter with a power-of-two window chosen at run time.
// Channels share one datapath and one history RAM, and are processed one after another.
module boxcar_filter_mc #(
    parameter int DW        = 16,
    parameter int MAX_DEPTH = 64,
    parameter int CHANNELS  = 2
) (
    input  logic                                     clk_i,
    input  logic                                     srst_n_i,
    input  logic                                     sample_tick_i,
    input  logic [CHANNELS*DW-1:0]                   data_i,
    input  logic [$clog2($clog2(MAX_DEPTH)+1)-1:0]   depth_log2_i,
    output logic [CHANNELS*DW-1:0]                   data_o,
    output logic                                     valid_o,
    output logic                                     overrun_o
);

    // state | meaning
    // IDLE  | waiting for sample_tick_i
    // RD    | history read issued for channel ch
    // ACC   | running sum update and history write for channel ch
    // OUT   | publish all channel outputs, advance pointer and fill count
    typedef enum logic [1:0] {IDLE, RD, ACC, OUT} state_t;

    localparam int AW   = $clog2(MAX_DEPTH);
    localparam int DLW  = $clog2(AW + 1);
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ACCW = DW + AW;

    state_t state_q, state_d;

    logic [CW-1:0]          ch;
    logic [AW-1:0]          wptr;
    logic [AW:0]            fill;
    logic [DLW-1:0]         dreg;
    logic [DLW-1:0]         depth_clamped;
    logic [CHANNELS*DW-1:0] sample_q;
    logic signed [ACCW-1:0] acc [CHANNELS];
    logic [DW-1:0]          mem [CHANNELS*MAX_DEPTH];
    logic [DW-1:0]          rd_data;
    logic [AW:0]            win;
    logic [AW-1:0]          rd_ptr;
    logic signed [DW-1:0]   cur;
    logic signed [DW-1:0]   old;
    logic                   last_ch;

    assign depth_clamped = (depth_log2_i > DLW'(AW)) ? DLW'(AW) : depth_log2_i;
    assign win           = (AW+1)'(1) << dreg;
    // At the full window the read lands on the slot about to be overwritten.
    assign rd_ptr        = wptr - win[AW-1:0];
    assign last_ch       = (ch == CW'(CHANNELS - 1));
    assign cur           = sample_q[ch*DW +: DW];
    assign old           = (fill >= win) ? rd_data : '0;

    always_ff @(posedge clk_i) begin
        if (state_q == RD) begin
            rd_data <= mem[{ch, rd_ptr}];
        end
        if (state_q == ACC) begin
            mem[{ch, wptr}] <= cur;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_tick_i) state_d = RD;
            RD:      state_d = ACC;
            ACC:     state_d = last_ch ? OUT : RD;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ch        <= '0;
            wptr      <= '0;
            fill      <= '0;
            dreg      <= '0;
            sample_q  <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            valid_o <= 1'b0;
            if (sample_tick_i && (state_q != IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sample_tick_i) begin
                        sample_q <= data_i;
                        ch       <= '0;
                        // A new window restarts warm-up from an empty history.
                        if (depth_clamped != dreg) begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                acc[c] <= '0;
                            end
                            fill <= '0;
                            dreg <= depth_clamped;
                        end
                    end
                end
                ACC: begin
                    acc[ch] <= acc[ch] + ACCW'(cur) - ACCW'(old);
                    if (!last_ch) begin
                        ch <= ch + 1'b1;
                    end
                end
                OUT: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        data_o[c*DW +: DW] <= DW'(acc[c] >>> dreg);
                    end
                    valid_o <= 1'b1;
                    wptr    <= wptr + 1'b1;
                    if (fill != (AW+1)'(MAX_DEPTH)) begin
                        fill <= fill + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boxcar_filter_mc.sv
// Self-checking bench for boxcar_filter_mc: table vectors plus a windowed-sum model
// feeding a scoreboard that is drained whenever valid_o pulses.
module tb_boxcar_filter_mc;

    localparam int DW        = 16;
    localparam int MAX_DEPTH = 64;
    localparam int CHANNELS  = 2;

    logic                   clk = 1'b0;
    logic                   srst_n = 1'b0;
    logic                   tick = 1'b0;
    logic [CHANNELS*DW-1:0] data = '0;
    logic [2:0]             depth = '0;
    logic [CHANNELS*DW-1:0] data_o;
    logic                   valid_o;
    logic                   overrun_o;

    always #5 clk = ~clk;

    boxcar_filter_mc #(.DW(DW), .MAX_DEPTH(MAX_DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk_i         (clk),
        .srst_n_i      (srst_n),
        .sample_tick_i (tick),
        .data_i        (data),
        .depth_log2_i  (depth),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .overrun_o     (overrun_o)
    );

    typedef struct {int e0; int e1; int tcyc;} exp_t;
    typedef struct {int d0; int d1; int dl; int e0; int e1;} vec_t;

    exp_t expq[$];
    vec_t vecs[$];
    int   h0[$];
    int   h1[$];
    int   mdreg = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (expq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                check("ch0_out", int'($signed(data_o[15:0])), e.e0);
                check("ch1_out", int'($signed(data_o[31:16])), e.e1);
                check("latency", cyc - e.tcyc, 5);
            end
        end
    end

    // Direct windowed sum over the samples seen since the last clear.
    task automatic model_step(input int d0, input int d1, input int dl, output int e0, output int e1);
        int     d;
        int     n;
        longint s0;
        longint s1;
        d = (dl > 6) ? 6 : dl;
        if (d != mdreg) begin
            h0.delete();
            h1.delete();
            mdreg = d;
        end
        h0.push_back(d0);
        h1.push_back(d1);
        if (h0.size() > MAX_DEPTH) begin
            void'(h0.pop_front());
            void'(h1.pop_front());
        end
        n  = 1 << d;
        s0 = 0;
        s1 = 0;
        for (int i = 0; i < n && i < h0.size(); i++) begin
            s0 += longint'(h0[h0.size()-1-i]);
            s1 += longint'(h1[h1.size()-1-i]);
        end
        e0 = int'(s0 >>> d);
        e1 = int'(s1 >>> d);
    endtask

    task automatic model_reset();
        h0.delete();
        h1.delete();
        mdreg = 0;
    endtask

    task automatic drive_tick(input int d0, input int d1, input int dl);
        tick  = 1'b1;
        data  = {d1[15:0], d0[15:0]};
        depth = dl[2:0];
        @(negedge clk);
        tick  = 1'b0;
    endtask

    task automatic push_exp(input int e0, input int e1);
        exp_t e;
        e.e0   = e0;
        e.e1   = e1;
        e.tcyc = cyc;
        expq.push_back(e);
    endtask

    task automatic send(input int d0, input int d1, input int dl,
                        input bit use_tab, input int t0, input int t1);
        int m0;
        int m1;
        model_step(d0, d1, dl, m0, m1);
        drive_tick(d0, d1, dl);
        if (use_tab) push_exp(t0, t1);
        else         push_exp(m0, m1);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        srst_n = 1'b0;
        repeat (2) @(negedge clk);
        srst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int m0;
        int m1;
        int dsel;
        logic [15:0] r0;
        logic [15:0] r1;
        int dl_list[5];

        // step at depth 4
        for (int i = 0; i < 6; i++) begin
            vecs.push_back('{1000, -4, 2, (i < 3) ? 250*(i+1) : 1000, (i < 3) ? -(i+1) : -4});
        end
        // impulse at depth 8
        vecs.push_back('{4096, 0, 3, 512, 0});
        for (int i = 0; i < 7; i++) vecs.push_back('{0, 0, 3, 512, 0});
        for (int i = 0; i < 2; i++) vecs.push_back('{0, 0, 3, 0, 0});
        // settle at depth 4, shrink to 2, then bypass
        vecs.push_back('{800, -800, 2, 200, -200});
        vecs.push_back('{800, -800, 2, 400, -400});
        vecs.push_back('{800, -800, 2, 600, -600});
        vecs.push_back('{800, -800, 2, 800, -800});
        vecs.push_back('{800, -800, 2, 800, -800});
        vecs.push_back('{800, -800, 1, 400, -400});
        vecs.push_back('{800, -800, 1, 800, -800});
        vecs.push_back('{800, -800, 0, 800, -800});
        vecs.push_back('{123, -77, 0, 123, -77});
        vecs.push_back('{-5, 9, 0, -5, 9});

        dl_list = '{0, 1, 2, 3, 5};

        repeat (3) @(negedge clk);
        check("reset_data_o", int'(data_o), 0);
        check("reset_valid_o", int'(valid_o), 0);
        check("reset_overrun_o", int'(overrun_o), 0);
        srst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].d0, vecs[i].d1, vecs[i].dl, 1'b1, vecs[i].e0, vecs[i].e1);
        end

        // full-scale ramps at the maximum window; 7 must clamp to 6 without a restart
        for (int i = 0; i < 70; i++) send(32767, -32768, 6, 1'b0, 0, 0);
        for (int i = 0; i < 70; i++) send(-32768, 32767, 7, 1'b0, 0, 0);

        dsel = 2;
        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 0) dsel = dl_list[$urandom_range(0, 4)];
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            send(int'($signed(r0)), int'($signed(r1)), dsel, 1'b0, 0, 0);
        end
        check("no_overrun_yet", int'(overrun_o), 0);

        // second tick three clocks after the first
        model_step(100, -100, 2, m0, m1);
        drive_tick(100, -100, 2);
        push_exp(m0, m1);
        repeat (2) @(negedge clk);
        drive_tick(555, 555, 2);
        repeat (8) @(negedge clk);
        check("overrun_set", int'(overrun_o), 1);
        send(300, 300, 2, 1'b0, 0, 0);
        check("overrun_sticky", int'(overrun_o), 1);
        do_reset();
        check("overrun_cleared", int'(overrun_o), 0);

        // tick coinciding with OUT
        model_step(64, -64, 1, m0, m1);
        drive_tick(64, -64, 1);
        push_exp(m0, m1);
        repeat (4) @(negedge clk);
        drive_tick(999, 999, 1);
        check("overrun_at_out", int'(overrun_o), 1);
        repeat (10) @(negedge clk);
        send(64, -64, 1, 1'b1, 64, -64);
        do_reset();

        // reset in ACC of the last channel aborts the sample
        send(400, 400, 0, 1'b1, 400, 400);
        drive_tick(1000, 1000, 2);
        repeat (3) @(negedge clk);
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        model_reset();
        check("abort_valid_o", int'(valid_o), 0);
        check("abort_data_o", int'(data_o), 0);
        repeat (6) @(negedge clk);
        check("abort_data_hold", int'(data_o), 0);
        send(1000, 1000, 2, 1'b1, 250, 250);

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
